// File: rtl/rtc_display_sched_pkg.sv
// Shared types and constants for the RTC display scheduler: state encoding,
// default sizing and the bus address of each display field.
package rtc_disp_pkg;

    localparam int NUM_FIELDS_DEF  = 9;
    localparam int ACK_TIMEOUT_DEF = 31;

    localparam logic [3:0] FLD_HOUR  = 4'd0;
    localparam logic [3:0] FLD_MIN   = 4'd1;
    localparam logic [3:0] FLD_SEC   = 4'd2;
    localparam logic [3:0] FLD_DAY   = 4'd3;
    localparam logic [3:0] FLD_MON   = 4'd4;
    localparam logic [3:0] FLD_YEAR  = 4'd5;
    localparam logic [3:0] FLD_THOUR = 4'd6;
    localparam logic [3:0] FLD_TMIN  = 4'd7;
    localparam logic [3:0] FLD_TSEC  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BUS,
        ST_RD_BUS,
        ST_RD_NEXT
    } sched_state_e;

endpackage

// File: rtl/rtc_display_sched_if.sv
// Time-register bus shared by the user-edit path and the display refresh scan.
// The scheduler is the master; the time-register block is the slave.
interface rtc_display_sched_if;

    logic       req;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/rtc_display_sched_shadow_regs.sv
// Shadow copy of the display fields, refreshed by the scan and read by the
// text overlay through a registered field-select port.
module rtc_shadow_regs
    import rtc_disp_pkg::*;
#(
    parameter int NUM_FIELDS = NUM_FIELDS_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_en_i,
    input  logic [3:0] wr_idx_i,
    input  logic [7:0] wr_data_i,
    input  logic [3:0] field_sel_i,
    output logic [3:0] dig0_o,
    output logic [3:0] dig1_o
);

    logic [7:0] shadow_q [NUM_FIELDS];
    logic [7:0] rd_d;
    logic [7:0] rd_q;

    // Selects outside the field range read as blank "00" rather than aliasing.
    always_comb begin
        rd_d = '0;
        if (int'(field_sel_i) < NUM_FIELDS) begin
            rd_d = shadow_q[field_sel_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_en_i && (int'(wr_idx_i) < NUM_FIELDS)) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
            rd_q <= rd_d;
        end
    end

    assign dig0_o = rd_q[7:4];
    assign dig1_o = rd_q[3:0];

endmodule

// File: rtl/rtc_display_sched.sv
// Arbitrates the time-register bus between user writes and the per-frame
// refresh scan that fills the display shadow file.
module rtc_display_sched
    import rtc_disp_pkg::*;
#(
    parameter int NUM_FIELDS  = NUM_FIELDS_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       vsync_start_i,
    input  logic                       wr_req_i,
    input  logic [3:0]                 wr_addr_i,
    input  logic [7:0]                 wr_data_i,
    output logic                       wr_done_o,
    rtc_display_sched_if.master        bus,
    input  logic [3:0]                 field_sel_i,
    output logic [3:0]                 dig0_o,
    output logic [3:0]                 dig1_o,
    output logic                       busy_o,
    output logic                       timeout_err_o
);

    localparam logic [3:0] LAST_IDX     = 4'(NUM_FIELDS - 1);
    localparam logic [4:0] TIMEOUT_LAST = 5'(ACK_TIMEOUT - 1);

    sched_state_e state_q;
    logic [3:0]   idx_q;
    logic [3:0]   idx_d;
    logic [4:0]   wait_cnt_q;
    logic         scan_pend_q;
    logic         suspended_q;
    logic         req_q;
    logic         we_q;
    logic [3:0]   addr_q;
    logic [7:0]   wdata_q;
    logic         wr_done_q;
    logic         busy_q;
    logic         timeout_err_q;
    logic         timed_out;
    logic         shadow_we;

    // idx is already advanced past the field read before a suspending write,
    // so the resume pass through RD_NEXT must reuse it instead of stepping again.
    assign idx_d     = suspended_q ? idx_q : idx_q + 4'd1;
    assign timed_out = (wait_cnt_q == TIMEOUT_LAST);
    assign shadow_we = (state_q == ST_RD_BUS) && req_q && bus.ack;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            wait_cnt_q    <= '0;
            scan_pend_q   <= 1'b0;
            suspended_q   <= 1'b0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_done_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            wr_done_q   <= 1'b0;
            scan_pend_q <= scan_pend_q | vsync_start_i;
            case (state_q)
                ST_IDLE: begin
                    if (wr_req_i) begin
                        state_q     <= ST_WR_BUS;
                        busy_q      <= 1'b1;
                        req_q       <= 1'b1;
                        we_q        <= 1'b1;
                        addr_q      <= wr_addr_i;
                        wdata_q     <= wr_data_i;
                        wait_cnt_q  <= '0;
                        suspended_q <= 1'b0;
                    end else if (scan_pend_q) begin
                        state_q     <= ST_RD_BUS;
                        scan_pend_q <= vsync_start_i;
                        busy_q      <= 1'b1;
                        req_q       <= 1'b1;
                        we_q        <= 1'b0;
                        addr_q      <= '0;
                        idx_q       <= '0;
                        wait_cnt_q  <= '0;
                    end
                end
                ST_WR_BUS: begin
                    if (bus.ack || timed_out) begin
                        if (!bus.ack) begin
                            timeout_err_q <= 1'b1;
                        end
                        req_q     <= 1'b0;
                        wr_done_q <= 1'b1;
                        if (suspended_q) begin
                            state_q <= ST_RD_NEXT;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 5'd1;
                    end
                end
                ST_RD_BUS: begin
                    if (bus.ack || timed_out) begin
                        if (!bus.ack) begin
                            timeout_err_q <= 1'b1;
                        end
                        req_q   <= 1'b0;
                        state_q <= ST_RD_NEXT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 5'd1;
                    end
                end
                ST_RD_NEXT: begin
                    if (!suspended_q && (idx_q == LAST_IDX)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q      <= idx_d;
                        req_q      <= 1'b1;
                        wait_cnt_q <= '0;
                        if (wr_req_i) begin
                            state_q     <= ST_WR_BUS;
                            suspended_q <= 1'b1;
                            we_q        <= 1'b1;
                            addr_q      <= wr_addr_i;
                            wdata_q     <= wr_data_i;
                        end else begin
                            state_q     <= ST_RD_BUS;
                            suspended_q <= 1'b0;
                            we_q        <= 1'b0;
                            addr_q      <= idx_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req       = req_q;
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign wr_done_o     = wr_done_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = timeout_err_q;

    rtc_shadow_regs #(
        .NUM_FIELDS(NUM_FIELDS)
    ) u_shadow (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_en_i     (shadow_we),
        .wr_idx_i    (idx_q),
        .wr_data_i   (bus.rdata),
        .field_sel_i (field_sel_i),
        .dig0_o      (dig0_o),
        .dig1_o      (dig1_o)
    );

endmodule

// File: tb/tb_rtc_display_sched.sv
// Directed bench for rtc_display_sched: scans, write preemption, queued scans,
// ack timeout, out-of-range field select and reset mid-transaction.
module tb_rtc_display_sched;
    import rtc_disp_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       vsync;
    logic       wrReq;
    logic [3:0] wrAddr;
    logic [7:0] wrData;
    logic       wrDone;
    logic [3:0] fieldSel;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic       busy;
    logic       timeoutErr;

    logic       ackEn;
    logic       dropEn;
    logic [3:0] dropAddr;
    int         reqCycles;
    logic [7:0] mem [16];
    logic       logWe   [$];
    logic [3:0] logAddr [$];
    logic [7:0] logData [$];

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    rtc_display_sched_if bus ();

    rtc_display_sched #(
        .NUM_FIELDS (9),
        .ACK_TIMEOUT(31)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .vsync_start_i(vsync),
        .wr_req_i     (wrReq),
        .wr_addr_i    (wrAddr),
        .wr_data_i    (wrData),
        .wr_done_o    (wrDone),
        .bus          (bus),
        .field_sel_i  (fieldSel),
        .dig0_o       (dig0),
        .dig1_o       (dig1),
        .busy_o       (busy),
        .timeout_err_o(timeoutErr)
    );

    // Time-register model: acks in the same cycle it sees req, logs every
    // completed transaction, and can withhold the ack for one address.
    initial begin
        bus.ack   = 1'b0;
        bus.rdata = '0;
        reqCycles = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
        forever begin
            @(posedge clk_i);
            #1;
            bus.ack = 1'b0;
            if (bus.req) begin
                if (dropEn && (bus.addr == dropAddr)) reqCycles++;
                if (ackEn && !(dropEn && (bus.addr == dropAddr))) begin
                    bus.ack = 1'b1;
                    logWe.push_back(bus.we);
                    logAddr.push_back(bus.addr);
                    if (bus.we) begin
                        mem[bus.addr] = bus.wdata;
                        logData.push_back(bus.wdata);
                    end else begin
                        bus.rdata = mem[bus.addr];
                        logData.push_back(mem[bus.addr]);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic vsPulse, input logic [3:0] sel);
        vsync    = vsPulse;
        fieldSel = sel;
        @(negedge clk_i);
        vsync = 1'b0;
    endtask

    task automatic checkDigits(input string tag, input logic [3:0] sel, input logic [3:0] e0, input logic [3:0] e1);
        fieldSel = sel;
        @(negedge clk_i);
        checkOutput({tag, "_dig0"}, 32'(dig0), 32'(e0));
        checkOutput({tag, "_dig1"}, 32'(dig1), 32'(e1));
    endtask

    task automatic waitReadAt(input string tag, input logic [3:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk_i);
            if (bus.req && !bus.we && (bus.addr == a)) found = 1'b1;
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    task automatic waitScanDone(output int busyCycles);
        busyCycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (busy) busyCycles++;
            else if (busyCycles > 0) break;
        end
    endtask

    initial begin
        int         base;
        int         baseReq;
        int         nBusy;
        int         doneCount;
        bit         found;
        logic [3:0] expAddr [10];
        logic       expWe   [10];

        rst_ni   = 1'b0;
        vsync    = 1'b0;
        wrReq    = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        fieldSel = '0;
        ackEn    = 1'b1;
        dropEn   = 1'b0;
        dropAddr = '0;

        repeat (3) @(negedge clk_i);
        checkOutput("rst_req",   32'(bus.req),    32'd0);
        checkOutput("rst_we",    32'(bus.we),     32'd0);
        checkOutput("rst_addr",  32'(bus.addr),   32'd0);
        checkOutput("rst_wdata", 32'(bus.wdata),  32'd0);
        checkOutput("rst_done",  32'(wrDone),     32'd0);
        checkOutput("rst_busy",  32'(busy),       32'd0);
        checkOutput("rst_terr",  32'(timeoutErr), 32'd0);
        checkOutput("rst_dig0",  32'(dig0),       32'd0);
        checkOutput("rst_dig1",  32'(dig1),       32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        $display("[TB] full scan");
        base = logAddr.size();
        applyStimulus(1'b1, 4'd0);
        waitScanDone(nBusy);
        checkOutput("scan1_busy_cycles", 32'(nBusy), 32'd18);
        checkOutput("scan1_count", 32'(logAddr.size() - base), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (base + i < logAddr.size()) begin
                checkOutput($sformatf("scan1_addr%0d", i), 32'(logAddr[base + i]), 32'(i));
                checkOutput($sformatf("scan1_we%0d", i), 32'(logWe[base + i]), 32'd0);
            end
        end
        checkDigits("year", FLD_YEAR, 4'd1, 4'd5);
        checkDigits("tsec", FLD_TSEC, 4'd1, 4'd8);
        checkDigits("sel12", 4'd12, 4'd0, 4'd0);

        $display("[TB] write preempts scan");
        base = logAddr.size();
        applyStimulus(1'b1, 4'd0);
        waitReadAt("pre_rd3", 4'd3);
        wrAddr = FLD_SEC;
        wrData = 8'h59;
        wrReq  = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_i);
            if (wrDone) begin
                found = 1'b1;
                wrReq = 1'b0;
            end
        end
        checkOutput("pre_wr_done", 32'(found), 32'd1);
        waitScanDone(nBusy);
        expAddr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        expWe   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checkOutput("pre_count", 32'(logAddr.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < logAddr.size()) begin
                checkOutput($sformatf("pre_addr%0d", i), 32'(logAddr[base + i]), 32'(expAddr[i]));
                checkOutput($sformatf("pre_we%0d", i), 32'(logWe[base + i]), 32'(expWe[i]));
            end
        end
        if (base + 4 < logData.size())
            checkOutput("pre_wdata", 32'(logData[base + 4]), 32'h59);
        checkDigits("sec_stale", FLD_SEC, 4'd1, 4'd2);
        checkDigits("mon", FLD_MON, 4'd1, 4'd4);

        $display("[TB] next scan picks up write");
        applyStimulus(1'b1, 4'd0);
        waitScanDone(nBusy);
        checkDigits("sec_new", FLD_SEC, 4'd5, 4'd9);

        $display("[TB] vsync mid-scan queues one scan");
        base = logAddr.size();
        applyStimulus(1'b1, 4'd0);
        waitReadAt("mid_rd4", 4'd4);
        applyStimulus(1'b1, 4'd0);
        waitReadAt("mid_rd6", 4'd6);
        applyStimulus(1'b1, 4'd0);
        repeat (80) @(negedge clk_i);
        checkOutput("mid_count", 32'(logAddr.size() - base), 32'd18);
        checkOutput("mid_busy", 32'(busy), 32'd0);

        $display("[TB] vsync on scan completion");
        base = logAddr.size();
        applyStimulus(1'b1, 4'd0);
        waitReadAt("end_rd8", 4'd8);
        @(negedge clk_i);
        applyStimulus(1'b1, 4'd0);
        repeat (60) @(negedge clk_i);
        checkOutput("end_count", 32'(logAddr.size() - base), 32'd18);

        $display("[TB] ack timeout");
        checkOutput("to_terr_before", 32'(timeoutErr), 32'd0);
        base     = logAddr.size();
        baseReq  = reqCycles;
        dropAddr = FLD_THOUR;
        dropEn   = 1'b1;
        applyStimulus(1'b1, 4'd0);
        repeat (100) @(negedge clk_i);
        checkOutput("to_req_cycles", 32'(reqCycles - baseReq), 32'd31);
        checkOutput("to_terr", 32'(timeoutErr), 32'd1);
        checkOutput("to_count", 32'(logAddr.size() - base), 32'd8);
        if (base + 6 < logAddr.size())
            checkOutput("to_next_addr", 32'(logAddr[base + 6]), 32'd7);
        checkOutput("to_busy", 32'(busy), 32'd0);
        dropEn = 1'b0;
        checkDigits("thour_kept", FLD_THOUR, 4'd1, 4'd6);

        $display("[TB] reset mid-write");
        ackEn  = 1'b0;
        wrAddr = FLD_MIN;
        wrData = 8'h33;
        wrReq  = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (bus.req) found = 1'b1;
        end
        checkOutput("rw_req_up", 32'(found), 32'd1);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        wrReq  = 1'b0;
        #1;
        checkOutput("rw_req_drop", 32'(bus.req), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ackEn  = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (wrDone) doneCount++;
        end
        checkOutput("rw_no_done", 32'(doneCount), 32'd0);
        checkOutput("rw_busy", 32'(busy), 32'd0);
        checkOutput("rw_terr", 32'(timeoutErr), 32'd0);
        checkDigits("rw_shadow_year", FLD_YEAR, 4'd0, 4'd0);
        checkDigits("rw_shadow_hour", FLD_HOUR, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_display_sched.md
# rtc_display_sched

Scheduler owning the single time-register bus between the user-edit path and the VGA text overlay. Once per frame, at vertical blank, it reads all nine display fields (hour/min/sec, day/month/year, timer h/m/s) into a shadow register file. The text unit reads digits from that file without touching the bus. User writes preempt the refresh scan between fields and always take priority.

## Interface
Parameters:
- NUM_FIELDS, 9: number of display fields scanned; field i lives at bus address i.
- ACK_TIMEOUT, 31: max wait cycles for bus_ack before abort (5-bit counter).

Ports:
- clk  in  1  system clock (undivided).
- reset  in  1  asynchronous, active-low reset.
- vsync_start  in  1  one-cycle pulse at start of vertical blank.
- wr_req  in  1  user write request; level, held until wr_done.
- wr_addr  in  4  target field address (direccion).
- wr_data  in  8  BCD pair {tens, units}.
- wr_done  out  1  one-cycle pulse, write completed or aborted.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write, 0 = read (W_R).
- bus_addr  out  4  transaction address.
- bus_wdata  out  8  write data.
- bus_ack  in  1  one-cycle completion strobe; sampled only while bus_req=1.
- bus_rdata  in  8  read data, valid with bus_ack.
- field_sel  in  4  field requested by text unit.
- dig0  out  4  tens digit of shadow[field_sel].
- dig1  out  4  units digit of shadow[field_sel].
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; set on any ack timeout, cleared only by reset.

## Operation
- States: IDLE, WR_BUS, RD_BUS, RD_NEXT.
- IDLE:
  - wr_req=1 -> WR_BUS.
  - Otherwise, scan_pend=1 -> RD_BUS with idx=0; scan_pend cleared.
  - Write wins if both are present.
- scan_pend is set by vsync_start in any state, including a pulse arriving mid-scan. It is cleared only when a scan starts at idx 0. A vsync during a scan therefore queues exactly one more scan.
- WR_BUS:
  - Drives bus_req=1, bus_we=1, bus_addr=wr_addr, bus_wdata=wr_data.
  - On bus_ack -> wr_done pulse.
  - Return to RD_NEXT if a scan was suspended, else IDLE.
  - The written field is not copied into shadow; the next scan refreshes it.
- RD_BUS:
  - Drives bus_req=1, bus_we=0, bus_addr=idx.
  - On bus_ack -> shadow[idx] <= bus_rdata, go to RD_NEXT.
- RD_NEXT:
  - idx==NUM_FIELDS-1 -> IDLE (scan complete).
  - Else, if wr_req=1 -> idx++ then WR_BUS (scan suspended).
  - Else idx++ -> RD_BUS.
- Timeout: the wait counter resets on entry to WR_BUS/RD_BUS. If it reaches ACK_TIMEOUT without ack:
  - drop bus_req and set timeout_err;
  - in WR_BUS, pulse wr_done;
  - in RD_BUS, leave shadow[idx] unchanged and go to RD_NEXT.
- Shadow: NUM_FIELDS x 8 bits. Any field_sel >= NUM_FIELDS yields dig0=dig1=0.
- Reset values: all outputs 0, shadow all 0, idx 0, scan_pend 0, state IDLE.

## Timing
- wr_req seen high in IDLE at cycle t -> bus_req=1 at t+1.
- bus_addr, bus_we and bus_wdata are stable for the whole time bus_req=1.
- bus_ack at cycle k:
  - bus_req=0 at k+1;
  - wr_done=1 at k+1 for writes;
  - shadow updated at k+1 for reads.
- Each transaction ends with at least one cycle of bus_req=0 (RD_NEXT/IDLE) before the next request.
- Full scan with single-cycle acks: 9 x (1 request + 1 gap) = 18 cycles after the IDLE decision.
- Timeout: bus_req is high for exactly ACK_TIMEOUT cycles, then low.
- dig0/dig1 are registered: field_sel at cycle t -> digits at t+1. A shadow update at t+1 is visible at t+2.
- Simultaneous vsync_start and scan completion: scan_pend=1 after the edge, and a new scan starts on the next IDLE cycle.
- Reset mid-transaction drops bus_req asynchronously; no wr_done is issued.

## Structure
- Package rtc_disp_pkg holds:
  - the state enum;
  - NUM_FIELDS default and ACK_TIMEOUT;
  - field address constants FLD_HOUR=0, FLD_MIN=1, FLD_SEC=2, FLD_DAY=3, FLD_MON=4, FLD_YEAR=5, FLD_THOUR=6, FLD_TMIN=7, FLD_TSEC=8.
- Sub-module rtc_shadow_regs holds the shadow file: one write port (idx, data, en) and the registered field_sel read port producing dig0/dig1.
- The FSM, idx and timeout counter stay in the top.

## Test plan
- Reset release, then vsync_start with ack one cycle after each req and rdata = 0x10+i -> nine reads at addr 0..8; field_sel=5 returns dig0=1, dig1=5; busy low after 18 cycles.
- wr_req (addr 2, data 0x59) raised while the read of idx 3 is pending -> idx 3 read completes, write at addr 2 with bus_we=1, wr_done pulses, then the scan resumes at addr 4.
- vsync_start pulsed at idx 4 of a scan -> exactly one more full scan follows; two pulses in one scan still yield only one extra scan.
- No ack on the read of addr 6 -> bus_req high 31 cycles, timeout_err=1, shadow[6] keeps its old value, scan continues at addr 7.
- field_sel=12 -> dig0=0, dig1=0.
- reset asserted while bus_req=1 -> bus_req=0 immediately; after release state is IDLE, shadow=0, and no wr_done is issued.
